// File: rtl/ahbl_master_if.sv
// AHB-Lite initiator: valid/ready request stream in, in-order response stream out.
// Address and data phases overlap; up to RSP_DEPTH transfers may be outstanding.
module ahbl_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RSP_DEPTH  = 4,
  parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_write_i,
  input  logic [2:0]            req_size_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] ahbl_haddr_o,
  output logic [2:0]            ahbl_hburst_o,
  output logic                  ahbl_hmastlock_o,
  output logic [3:0]            ahbl_hprot_o,
  output logic [2:0]            ahbl_hsize_o,
  output logic [1:0]            ahbl_htrans_o,
  output logic [DATA_WIDTH-1:0] ahbl_hwdata_o,
  output logic                  ahbl_hwrite_o,
  input  logic [DATA_WIDTH-1:0] ahbl_hrdata_i,
  input  logic                  ahbl_hready_i,
  input  logic                  ahbl_hresp_i
);
  localparam int unsigned   PW      = $clog2(RSP_DEPTH);
  localparam int unsigned   CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
  localparam logic [1:0]    HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]    HTRANS_NONSEQ = 2'b10;

  // address-phase register
  logic                  a_valid_q, a_valid_d;
  logic [ADDR_WIDTH-1:0] a_addr_q,  a_addr_d;
  logic                  a_write_q, a_write_d;
  logic [2:0]            a_size_q,  a_size_d;
  logic [DATA_WIDTH-1:0] a_wdata_q, a_wdata_d;
  // data-phase register
  logic                  d_valid_q, d_valid_d;
  logic                  d_write_q, d_write_d;
  logic [DATA_WIDTH-1:0] d_wdata_q, d_wdata_d;
  // response FIFO, pointers carry one wrap bit
  logic [DATA_WIDTH:0]   fifo_q [RSP_DEPTH];
  logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         out_q, out_d;

  logic                  accept, a_adv, d_done, pop, fifo_empty;
  logic [DATA_WIDTH:0]   push_data;

  assign a_adv       = a_valid_q && ahbl_hready_i;
  assign d_done      = d_valid_q && ahbl_hready_i;
  assign req_ready_o = (out_q < DEPTH_C) && (!a_valid_q || ahbl_hready_i);
  assign accept      = req_valid_i && req_ready_o;
  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign pop         = !fifo_empty && rsp_ready_i;

  // Errored and write transfers both report zero read data.
  assign push_data = {ahbl_hresp_i,
                      (d_write_q || ahbl_hresp_i) ? {DATA_WIDTH{1'b0}} : ahbl_hrdata_i};

  always_comb begin
    a_valid_d = a_valid_q;
    a_addr_d  = a_addr_q;
    a_write_d = a_write_q;
    a_size_d  = a_size_q;
    a_wdata_d = a_wdata_q;
    d_valid_d = d_valid_q;
    d_write_d = d_write_q;
    d_wdata_d = d_wdata_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    out_d     = out_q;
    if (accept) begin
      a_valid_d = 1'b1;
      a_addr_d  = req_addr_i;
      a_write_d = req_write_i;
      a_size_d  = req_size_i;
      a_wdata_d = req_wdata_i;
    end else if (a_adv) begin
      a_valid_d = 1'b0;
    end
    if (a_adv) begin
      d_valid_d = 1'b1;
      d_write_d = a_write_q;
      d_wdata_d = a_wdata_q;
    end else if (d_done) begin
      d_valid_d = 1'b0;
    end
    if (d_done) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
    case ({accept, pop})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_addr_q  <= '0;
      a_write_q <= 1'b0;
      a_size_q  <= '0;
      a_wdata_q <= '0;
      d_valid_q <= 1'b0;
      d_write_q <= 1'b0;
      d_wdata_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      out_q     <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_addr_q  <= a_addr_d;
      a_write_q <= a_write_d;
      a_size_q  <= a_size_d;
      a_wdata_q <= a_wdata_d;
      d_valid_q <= d_valid_d;
      d_write_q <= d_write_d;
      d_wdata_q <= d_wdata_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      out_q     <= out_d;
    end
  end

  // Storage only; emptiness is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (!rst && d_done) fifo_q[wr_ptr_q[PW-1:0]] <= push_data;
  end

  assign rsp_valid_o      = !fifo_empty;
  assign rsp_rdata_o      = fifo_empty ? '0 : fifo_q[rd_ptr_q[PW-1:0]][DATA_WIDTH-1:0];
  assign rsp_err_o        = fifo_empty ? 1'b0 : fifo_q[rd_ptr_q[PW-1:0]][DATA_WIDTH];

  assign ahbl_haddr_o     = a_addr_q;
  assign ahbl_hwrite_o    = a_write_q;
  assign ahbl_hsize_o     = a_size_q;
  assign ahbl_htrans_o    = a_valid_q ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahbl_hwdata_o    = d_wdata_q;
  assign ahbl_hburst_o    = 3'b000;
  assign ahbl_hmastlock_o = 1'b0;
  assign ahbl_hprot_o     = HPROT_VAL;

endmodule

// File: tb/tb_ahbl_master_if.sv
// Bench for ahbl_master_if: behavioural AHB-Lite memory slave plus an in-order
// flat-memory reference model that predicts every response at request accept time.
module tb_ahbl_master_if;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        rsp_force, rsp_rand, rnd_bit;
  logic [31:0] haddr, hwdata, hrdata;
  logic [2:0]  hburst, hsize;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock, hwrite, hready, hresp;

  typedef struct packed {logic [31:0] rdata; logic err;} rsp_t;
  rsp_t        exp_q[$], got_q[$];
  logic [31:0] model_mem[logic [31:0]];
  logic [31:0] smem[logic [31:0]];
  logic [31:0] preload[logic [31:0]];
  bit          err_addr[logic [31:0]];
  int          wait_cfg[logic [31:0]];
  bit          rand_waits;
  int          n_chk = 0, n_pass = 0, cyc = 0, eb = 0, gb = 0;

  assign rsp_ready = rsp_rand ? rnd_bit : rsp_force;

  ahbl_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RSP_DEPTH(4), .HPROT_VAL(4'b0011)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_write_i(req_write), .req_size_i(req_size), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .ahbl_haddr_o(haddr), .ahbl_hburst_o(hburst), .ahbl_hmastlock_o(hmastlock),
    .ahbl_hprot_o(hprot), .ahbl_hsize_o(hsize), .ahbl_htrans_o(htrans),
    .ahbl_hwdata_o(hwdata), .ahbl_hwrite_o(hwrite), .ahbl_hrdata_i(hrdata),
    .ahbl_hready_i(hready), .ahbl_hresp_i(hresp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [31:0] init_val(input logic [31:0] a);
    if (preload.exists(a)) return preload[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] sl_rd(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : init_val(a);
  endfunction

  initial begin
    rnd_bit = 1'b0;
    forever begin
      @(posedge clk); #2;
      rnd_bit = 1'($urandom);
    end
  end

  // Behavioural slave: sees the bus as it stood before each edge.
  logic        sl_v, sl_w, sl_e;
  logic [31:0] sl_a, p_haddr, p_hwdata;
  logic [1:0]  p_htrans;
  logic        p_hwrite;
  int          sl_cnt;
  initial begin
    hready = 1'b1; hresp = 1'b0; hrdata = '0; sl_v = 1'b0; sl_w = 1'b0; sl_e = 1'b0;
    sl_a = '0; sl_cnt = 0; p_htrans = 2'b00; p_haddr = '0; p_hwdata = '0; p_hwrite = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        sl_v = 1'b0;
      end else begin
        if (sl_v && hready && sl_w && !sl_e) smem[sl_a] = p_hwdata;
        if (hready && p_htrans == 2'b10) begin
          sl_v = 1'b1; sl_a = p_haddr; sl_w = p_hwrite; sl_e = err_addr.exists(p_haddr);
          if (sl_e) sl_cnt = 1;
          else if (wait_cfg.exists(p_haddr)) sl_cnt = wait_cfg[p_haddr];
          else sl_cnt = rand_waits ? $urandom_range(0, 2) : 0;
        end else if (sl_v && hready) begin
          sl_v = 1'b0;
        end
      end
      if (sl_v) begin
        if (sl_cnt > 0) begin hready = 1'b0; sl_cnt--; end
        else hready = 1'b1;
        hresp  = sl_e;
        hrdata = (hready && !sl_w && !sl_e) ? sl_rd(sl_a) : $urandom;
      end else begin
        hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
      end
      p_htrans = htrans; p_haddr = haddr; p_hwrite = hwrite; p_hwdata = hwdata;
    end
  end

  // Reference model: flat memory, transfers complete in accept order.
  rsp_t        mon_e;
  logic [31:0] mon_v;
  initial forever begin
    @(negedge clk);
    if (rst === 1'b0 && req_valid && req_ready) begin
      mon_e.err   = err_addr.exists(req_addr);
      mon_v       = model_mem.exists(req_addr) ? model_mem[req_addr] : init_val(req_addr);
      mon_e.rdata = (req_write || mon_e.err) ? 32'h0 : mon_v;
      if (req_write && !mon_e.err) model_mem[req_addr] = req_wdata;
      exp_q.push_back(mon_e);
    end
    if (rst === 1'b0 && rsp_valid && rsp_ready) got_q.push_back({rsp_rdata, rsp_err});
  end

  task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] d);
    int t; logic acc;
    req_addr = a; req_write = w; req_size = s; req_wdata = d; req_valid = 1'b1; t = 0;
    do begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); #2; t++;
    end while (!acc && t < 60);
    if (!acc) begin
      n_chk++; req_valid = 1'b0;
      $display("FAIL issue_timeout: addr %h not accepted after %0d cycles", a, t);
    end
  endtask

  task automatic offer(input logic [31:0] base, input int n, input int window, output int acc);
    logic a;
    acc = 0; req_addr = base; req_write = 1'b0; req_size = 3'b010; req_wdata = '0; req_valid = 1'b1;
    for (int c = 0; c < window && acc < n; c++) begin
      @(negedge clk); a = req_ready;
      @(posedge clk); #2;
      if (a) begin acc++; req_addr = base + 32'(4 * acc); end
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int t = 0;
    while (got_q.size() < gb + n && t < 3000) begin @(posedge clk); #2; t++; end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
    rsp_force = 1'b1; rsp_rand = 1'b0; rand_waits = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    n_chk++; if (htrans !== 2'b00) $display("FAIL reset_htrans: got %b want 00", htrans); else n_pass++;
    n_chk++; if (haddr !== 32'h0) $display("FAIL reset_haddr: got %h want 0", haddr); else n_pass++;
    n_chk++; if (hwdata !== 32'h0) $display("FAIL reset_hwdata: got %h want 0", hwdata); else n_pass++;
    n_chk++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else n_pass++;
    n_chk++; if (hburst !== 3'b000) $display("FAIL reset_hburst: got %b want 000", hburst); else n_pass++;
    n_chk++; if (hprot !== 4'b0011) $display("FAIL reset_hprot: got %b want 0011", hprot); else n_pass++;
    n_chk++; if (hmastlock !== 1'b0) $display("FAIL reset_hmastlock: got %b want 0", hmastlock); else n_pass++;
  endtask

  task automatic test_single_read;
    preload[32'h100] = 32'hDEADBEEF;
    issue(32'h100, 1'b0, 3'b010, 32'h0);
    req_valid = 1'b0;
    n_chk++; if (htrans !== 2'b10) $display("FAIL sr_htrans_n1: got %b want 10", htrans); else n_pass++;
    n_chk++; if (haddr !== 32'h100) $display("FAIL sr_haddr_n1: got %h want 100", haddr); else n_pass++;
    n_chk++; if (hsize !== 3'b010) $display("FAIL sr_hsize_n1: got %b want 010", hsize); else n_pass++;
    n_chk++; if (hwrite !== 1'b0) $display("FAIL sr_hwrite_n1: got %b want 0", hwrite); else n_pass++;
    n_chk++; if (rsp_valid !== 1'b0) $display("FAIL sr_rsp_valid_n1: got %b want 0", rsp_valid); else n_pass++;
    @(posedge clk); #2;
    n_chk++; if (htrans !== 2'b00) $display("FAIL sr_htrans_n2: got %b want 00", htrans); else n_pass++;
    n_chk++; if (rsp_valid !== 1'b0) $display("FAIL sr_rsp_valid_n2: got %b want 0", rsp_valid); else n_pass++;
    @(posedge clk); #2;
    n_chk++; if (rsp_valid !== 1'b1) $display("FAIL sr_rsp_valid_n3: got %b want 1", rsp_valid); else n_pass++;
    n_chk++; if (rsp_rdata !== 32'hDEADBEEF) $display("FAIL sr_rdata: got %h want deadbeef", rsp_rdata); else n_pass++;
    n_chk++; if (rsp_err !== 1'b0) $display("FAIL sr_err: got %b want 0", rsp_err); else n_pass++;
    wait_rsp(1);
    n_chk++; if (got_q.size() !== gb + 1) $display("FAIL sr_count: got %0d want %0d", got_q.size() - gb, 1); else n_pass++;
    gb = got_q.size(); eb = exp_q.size();
  endtask

  task automatic test_write_read_wait;
    int g0 = gb;
    wait_cfg[32'h200] = 2;
    issue(32'h200, 1'b1, 3'b010, 32'h12345678);
    issue(32'h204, 1'b0, 3'b010, 32'h0);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (hwdata !== 32'h12345678) $display("FAIL wr_hwdata_c%0d: got %h want 12345678", i, hwdata); else n_pass++;
      n_chk++; if (htrans !== 2'b10 || haddr !== 32'h204) $display("FAIL wr_addr_c%0d: got %b/%h want 10/204", i, htrans, haddr); else n_pass++;
      @(posedge clk); #2;
    end
    issue(32'h200, 1'b0, 3'b010, 32'h0);
    req_valid = 1'b0;
    wait_rsp(3);
    n_chk++; if (got_q.size() !== gb + 3) $display("FAIL wr_count: got %0d want 3", got_q.size() - gb); else n_pass++;
    if (got_q.size() >= g0 + 3) begin
      n_chk++; if (got_q[g0].rdata !== 32'h0) $display("FAIL wr_write_rdata: got %h want 0", got_q[g0].rdata); else n_pass++;
      n_chk++; if (got_q[g0 + 2].rdata !== 32'h12345678) $display("FAIL wr_readback: got %h want 12345678", got_q[g0 + 2].rdata); else n_pass++;
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (got_q[gb + i] !== exp_q[eb + i])
          $display("FAIL wr_rsp%0d: got %h/%b want %h/%b", i, got_q[gb + i].rdata, got_q[gb + i].err, exp_q[eb + i].rdata, exp_q[eb + i].err);
        else n_pass++;
      end
    end
    gb = got_q.size(); eb = exp_q.size();
  endtask

  task automatic test_error;
    err_addr[32'h300] = 1'b1;
    issue(32'h300, 1'b0, 3'b010, 32'h0);
    issue(32'h304, 1'b0, 3'b010, 32'h0);
    req_valid = 1'b0;
    wait_rsp(2);
    n_chk++; if (got_q.size() !== gb + 2) $display("FAIL err_count: got %0d want 2", got_q.size() - gb); else n_pass++;
    if (got_q.size() >= gb + 2) begin
      n_chk++; if (got_q[gb].err !== 1'b1) $display("FAIL err_flag: got %b want 1", got_q[gb].err); else n_pass++;
      n_chk++; if (got_q[gb].rdata !== 32'h0) $display("FAIL err_rdata: got %h want 0", got_q[gb].rdata); else n_pass++;
      n_chk++; if (got_q[gb + 1].err !== 1'b0) $display("FAIL err_next_flag: got %b want 0", got_q[gb + 1].err); else n_pass++;
      n_chk++; if (got_q[gb + 1].rdata !== init_val(32'h304)) $display("FAIL err_next_rdata: got %h want %h", got_q[gb + 1].rdata, init_val(32'h304)); else n_pass++;
    end
    gb = got_q.size(); eb = exp_q.size();
  endtask

  task automatic test_backpressure;
    int acc;
    rsp_force = 1'b0;
    offer(32'h400, 6, 12, acc);
    n_chk++; if (acc !== 4) $display("FAIL bp_accepted: got %0d want 4", acc); else n_pass++;
    n_chk++; if (req_ready !== 1'b0) $display("FAIL bp_req_ready: got %b want 0", req_ready); else n_pass++;
    n_chk++; if (htrans !== 2'b00) $display("FAIL bp_htrans: got %b want 00", htrans); else n_pass++;
    n_chk++; if (rsp_valid !== 1'b1) $display("FAIL bp_rsp_valid: got %b want 1", rsp_valid); else n_pass++;
    rsp_force = 1'b1;
    offer(32'h410, 2, 20, acc);
    n_chk++; if (acc !== 2) $display("FAIL bp_rest_accepted: got %0d want 2", acc); else n_pass++;
    wait_rsp(6);
    n_chk++; if (got_q.size() !== gb + 6) $display("FAIL bp_count: got %0d want 6", got_q.size() - gb); else n_pass++;
    for (int i = 0; i < 6; i++) if (gb + i < got_q.size() && eb + i < exp_q.size()) begin
      n_chk++;
      if (got_q[gb + i] !== exp_q[eb + i])
        $display("FAIL bp_rsp%0d: got %h/%b want %h/%b", i, got_q[gb + i].rdata, got_q[gb + i].err, exp_q[eb + i].rdata, exp_q[eb + i].err);
      else n_pass++;
    end
    gb = got_q.size(); eb = exp_q.size();
  endtask

  task automatic test_back_to_back;
    int c0;
    rsp_force = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 8; i++) issue(32'h700 + 32'(4 * i), 1'(i % 2), 3'b010, $urandom);
    req_valid = 1'b0;
    n_chk++; if (cyc - c0 !== 8) $display("FAIL b2b_cycles: got %0d want 8", cyc - c0); else n_pass++;
    wait_rsp(8);
    n_chk++; if (got_q.size() !== gb + 8) $display("FAIL b2b_count: got %0d want 8", got_q.size() - gb); else n_pass++;
    for (int i = 0; i < 8; i++) if (gb + i < got_q.size() && eb + i < exp_q.size()) begin
      n_chk++;
      if (got_q[gb + i] !== exp_q[eb + i])
        $display("FAIL b2b_rsp%0d: got %h/%b want %h/%b", i, got_q[gb + i].rdata, got_q[gb + i].err, exp_q[eb + i].rdata, exp_q[eb + i].err);
      else n_pass++;
    end
    gb = got_q.size(); eb = exp_q.size();
  endtask

  task automatic test_reset_mid;
    int acc;
    wait_cfg[32'h500] = 5;
    rsp_force = 1'b1;
    issue(32'h500, 1'b1, 3'b010, 32'hCAFEF00D);
    req_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    n_chk++; if (htrans !== 2'b00) $display("FAIL rm_htrans: got %b want 00", htrans); else n_pass++;
    n_chk++; if (rsp_valid !== 1'b0) $display("FAIL rm_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL rm_req_ready: got %b want 1", req_ready); else n_pass++;
    n_chk++; if (haddr !== 32'h0) $display("FAIL rm_haddr: got %h want 0", haddr); else n_pass++;
    eb = exp_q.size(); gb = got_q.size();
    repeat (6) @(posedge clk);
    #2;
    n_chk++; if (got_q.size() !== gb) $display("FAIL rm_no_rsp: got %0d responses want 0", got_q.size() - gb); else n_pass++;
    rsp_force = 1'b0;
    offer(32'h600, 5, 10, acc);
    n_chk++; if (acc !== 4) $display("FAIL rm_out_cleared: accepted %0d want 4", acc); else n_pass++;
    rsp_force = 1'b1;
    wait_rsp(4);
    n_chk++; if (got_q.size() !== gb + 4) $display("FAIL rm_count: got %0d want 4", got_q.size() - gb); else n_pass++;
    for (int i = 0; i < 4; i++) if (gb + i < got_q.size() && eb + i < exp_q.size()) begin
      n_chk++;
      if (got_q[gb + i] !== exp_q[eb + i])
        $display("FAIL rm_rsp%0d: got %h/%b want %h/%b", i, got_q[gb + i].rdata, got_q[gb + i].err, exp_q[eb + i].rdata, exp_q[eb + i].err);
      else n_pass++;
    end
    gb = got_q.size(); eb = exp_q.size();
  endtask

  task automatic test_random;
    localparam int N = 150;
    rand_waits = 1'b1;
    err_addr[32'h1010] = 1'b1;
    rsp_rand = 1'b1;
    for (int i = 0; i < N; i++) begin
      issue(32'h1000 + 32'(4 * $urandom_range(0, 15)), 1'($urandom), 3'($urandom_range(0, 2)), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #2;
      end
    end
    req_valid = 1'b0;
    rsp_rand = 1'b0;
    rsp_force = 1'b1;
    wait_rsp(N);
    n_chk++; if (got_q.size() !== gb + N) $display("FAIL rnd_count: got %0d want %0d", got_q.size() - gb, N); else n_pass++;
    for (int i = 0; i < N; i++) if (gb + i < got_q.size() && eb + i < exp_q.size()) begin
      n_chk++;
      if (got_q[gb + i] !== exp_q[eb + i])
        $display("FAIL rnd_rsp%0d: got %h/%b want %h/%b", i, got_q[gb + i].rdata, got_q[gb + i].err, exp_q[eb + i].rdata, exp_q[eb + i].err);
      else n_pass++;
    end
    gb = got_q.size(); eb = exp_q.size();
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_write_read_wait;
    test_error;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ahbl_master_if.md
Name: ahbl_master_if

Overview:
- Generic AHB-Lite initiator.
- Converts a simple valid/ready request stream and a response stream into AHB-Lite SINGLE/NONSEQ transfers, with address and data phases overlapped.
- Provides the master end of the same bus that the instruction and data SRAM responders implement. Test benches, loaders and future DMA logic use it to drive those SRAMs.
- Keeps up to RSP_DEPTH transfers outstanding and returns responses in order.

Parameters:
ADDR_WIDTH, 32, haddr/req_addr width
DATA_WIDTH, 32, hwdata/hrdata width
RSP_DEPTH, 4, response FIFO depth = max outstanding requests (power of 2, >=2)
HPROT_VAL, 4'b0011, constant hprot value

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready at rising clk
req_addr_i  in  ADDR_WIDTH  byte address
req_write_i  in  1  1=write, 0=read
req_size_i  in  3  hsize encoding
req_wdata_i  in  DATA_WIDTH  write data
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes
rsp_err_o  out  1  slave returned ERROR
ahbl_haddr_o  out  ADDR_WIDTH  address
ahbl_hburst_o  out  3  constant 3'b000 (SINGLE)
ahbl_hmastlock_o  out  1  constant 0
ahbl_hprot_o  out  4  constant HPROT_VAL
ahbl_hsize_o  out  3  transfer size
ahbl_htrans_o  out  2  2'b00 IDLE / 2'b10 NONSEQ only
ahbl_hwdata_o  out  DATA_WIDTH  write data (data phase)
ahbl_hwrite_o  out  1  direction
ahbl_hrdata_i  in  DATA_WIDTH  read data
ahbl_hready_i  in  1  slave ready
ahbl_hresp_i  in  1  slave error response

Behaviour:
- Reset (synchronous, rst=1 at rising edge), effective the following cycle:
  - htrans=00; haddr, hsize, hwrite and hwdata all 0.
  - Phase registers cleared; response FIFO emptied; outstanding counter OUT=0.
  - rsp_valid_o=0; req_ready_o=1 once rst is low.
  - Any in-flight bus transfer is abandoned and produces no response.
- Three state elements: the address-phase register (A), the data-phase register (D) and the response FIFO.
- OUT counter:
  - +1 on request accept, -1 on response pop.
  - Accept and pop in the same cycle leave OUT unchanged.
  - OUT never exceeds RSP_DEPTH.
- req_ready_o = (OUT < RSP_DEPTH) && (!A.valid || ahbl_hready_i). This is a combinational path from hready; it is allowed.
- Accept:
  - Load A with addr, write, size and wdata.
  - htrans=NONSEQ starting the next cycle.
  - haddr, hwrite and hsize come directly from A.
- Address phase end (rising edge with A.valid && hready_i):
  - Move A into D (valid, write, wdata).
  - If a new request is accepted on the same edge, reload A, giving back-to-back NONSEQ.
  - Otherwise clear A.valid; htrans=IDLE and haddr/hwrite/hsize hold their last values.
- While hready_i=0, A, htrans and hwdata hold stable.
- hwdata_o = D.wdata throughout the data phase; it holds its last value otherwise.
- Data phase end (rising edge with D.valid && hready_i):
  - Push {rdata = D.write ? 0 : hrdata_i, err = hresp_i} into the FIFO.
  - Clear D.valid unless it is being reloaded from A.
- ERROR response (cycle 1: hresp=1, hready=0; cycle 2: hresp=1, hready=1):
  - Response err=1, rdata=0.
  - A pending address phase is not cancelled; it completes normally.
- FIFO:
  - Push and pop may occur in the same cycle, including when the FIFO is full.
  - Overflow is impossible by the OUT rule.
  - rsp_valid_o = FIFO not empty.
  - rsp_rdata_o/rsp_err_o come from the FIFO head; both are 0 when empty.
- Latency: accept at edge n → NONSEQ during cycle n+1 → data phase cycle n+2 (zero wait) → rsp_valid_o high cycle n+3.
- With RSP_DEPTH=4 and rsp_ready_i=1, sustained throughput is 1 transfer/cycle.
- No alignment or size checking: requests go to the bus unchanged.
- Only a single master and a single slave segment are supported, so hready_i acts as HREADYIN.

Test Plan:
1. Reset:
   - Stimulus: rst=1 for 2 cycles, then rst=0.
   - Response: htrans=00, haddr=0, rsp_valid_o=0, req_ready_o=1, hburst=000, hprot=0011.
2. Single read, zero wait:
   - Stimulus: req addr 0x0000_0100, size 3'b010, read. Slave gives hrdata=0xDEADBEEF, hready=1.
   - Response: NONSEQ/haddr 0x100 at cycle+1; rsp_valid at cycle+3 with rdata 0xDEADBEEF, err=0.
3. Write then read, back-to-back, wait states:
   - Stimulus: write 0x200 = 0x12345678, then read 0x204. Slave holds hready=0 for 2 cycles in the write data phase.
   - Response: hwdata=0x12345678 and NONSEQ haddr=0x204 stable for 3 cycles; responses in order: write (rdata 0), then read.
4. Error:
   - Stimulus: slave returns two-cycle ERROR on a read to 0x300 while a read to 0x304 is pending.
   - Response: first response err=1, rdata=0; second transfer completes with err=0.
5. Backpressure:
   - Stimulus: rsp_ready_i=0, offer 6 reads; then raise rsp_ready_i.
   - Response: exactly 4 accepted, req_ready_o=0, htrans=IDLE after the 4th address phase. After release: 4 in-order responses, then the remaining 2 accepted and completed.
6. Reset mid-transfer:
   - Stimulus: rst=1 during a write data phase wait state.
   - Response: next cycle htrans=00, rsp_valid_o=0, OUT=0; no response for the aborted transfer.
